// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the 4:1 data mux select; bounded bursts,
// valid/ready output. Ports: clk, rst, req[3:0], a..d, gnt, sel, out,
// out_valid, out_ready.
module mux_rr_arbiter #(
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    req,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] c,
  input  logic [DW-1:0] d,
  output logic [3:0]    gnt,
  output logic [1:0]    sel,
  output logic [DW-1:0] out,
  output logic          out_valid,
  input  logic          out_ready
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [3:0] LAST_BEAT = 4'(MAX_HOLD - 1);

  state_t     state;
  state_t     state_nx;
  logic [1:0] last;
  logic [3:0] cnt;

  logic [3:0] gnt_nx;
  logic [1:0] sel_nx;
  logic [1:0] last_nx;
  logic [3:0] cnt_nx;

  logic [1:0] pick;
  logic [1:0] scan;
  logic       hit;
  logic       accept;

  // Scan starts just after the last winner and ends on it,
  // so the most recent owner has the lowest priority.
  always_comb begin
    pick = last;
    scan = last;
    hit  = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      scan = last + 2'(i);
      if (!hit && req[scan]) begin
        pick = scan;
        hit  = 1'b1;
      end
    end
  end

  assign out_valid = (state == GRANT) && req[sel];
  assign accept    = out_valid && out_ready;

  always_comb begin
    out = a;
    unique case (sel)
      2'd0: out = a;
      2'd1: out = b;
      2'd2: out = c;
      2'd3: out = d;
      default: out = a;
    endcase
  end

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    sel_nx   = sel;
    last_nx  = last;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (hit) begin
          state_nx = GRANT;
          gnt_nx   = 4'b0001 << pick;
          sel_nx   = pick;
          last_nx  = pick;
          cnt_nx   = 4'd0;
        end
      end
      GRANT: begin
        // A withdrawn request blocks the beat, so the
        // withdrawal check comes first.
        if (!req[sel]) begin
          state_nx = IDLE;
          gnt_nx   = 4'b0000;
          cnt_nx   = 4'd0;
        end else if (accept) begin
          if (cnt == LAST_BEAT) begin
            state_nx = IDLE;
            gnt_nx   = 4'b0000;
            cnt_nx   = 4'd0;
          end else begin
            cnt_nx = cnt + 4'd1;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = 4'b0000;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 4'b0000;
      sel   <= 2'd0;
      last  <= 2'd3;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      gnt   <= gnt_nx;
      sel   <= sel_nx;
      last  <= last_nx;
      cnt   <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed phases, abstract owner/count model
// checked every cycle, plus literal expectations per phase.
module tb_mux_rr_arbiter;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [7:0] a, b, c, d;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic [7:0] out;
  logic       out_valid;
  logic       out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  mux_rr_arbiter #(.DW(8), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req(req),
    .a(a), .b(b), .c(c), .d(d),
    .gnt(gnt), .sel(sel), .out(out),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: who owns the mux (-1 = nobody), beats taken, last winner.
  int m_own  = -1;
  int m_cnt  = 0;
  int m_last = 3;
  int m_sel  = 0;
  int m_beats[4];
  int g_log[$];
  int dut_acc[4];
  bit started = 0;

  always @(posedge clk) begin
    bit found;
    int j;
    if (rst) begin
      m_own = -1; m_cnt = 0; m_last = 3; m_sel = 0;
    end else if (m_own < 0) begin
      found = 0;
      for (int k = 1; k <= 4; k++) begin
        j = (m_last + k) % 4;
        if (!found && req[j]) begin
          found = 1;
          m_own = j; m_sel = j; m_last = j; m_cnt = 0;
          g_log.push_back(j);
        end
      end
    end else if (!req[m_own]) begin
      m_own = -1; m_cnt = 0;
    end else if (out_ready) begin
      m_beats[m_own]++;
      m_cnt++;
      if (m_cnt == MH) begin
        m_own = -1; m_cnt = 0;
      end
    end
    started = 1;
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (!rst && gnt[i] && out_valid && out_ready) dut_acc[i]++;
  end

  function automatic logic [7:0] src(int i);
    case (i)
      0: return a;
      1: return b;
      2: return c;
      default: return d;
    endcase
  endfunction

  always @(negedge clk) begin
    logic [3:0] eg;
    logic       ev;
    if (started) begin
      eg = (m_own < 0) ? 4'b0 : 4'(1 << m_own);
      ev = (m_own >= 0) && req[m_own];
      chk("m_gnt", gnt, eg);
      chk("m_sel", sel, m_sel);
      chk("m_valid", out_valid, ev);
      chk("m_out", out, src(m_sel));
    end
  end

  bit fix_b = 0;

  task automatic tick();
    @(posedge clk);
    #2;
    a = 8'($urandom);
    c = 8'($urandom);
    d = 8'($urandom);
    if (!fix_b) b = 8'($urandom);
  endtask

  task automatic reset1();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int rot[5];
    logic pat[7];
    rot = '{0, 1, 2, 3, 0};
    pat = '{1, 0, 0, 1, 1, 0, 1};
    rst = 1'b1;
    req = 4'($urandom);
    out_ready = 1'b1;
    a = 8'($urandom); b = 8'($urandom);
    c = 8'($urandom); d = 8'($urandom);

    // reset held two cycles with random req
    tick();
    req = 4'($urandom);
    tick();
    rst = 1'b0;
    req = 4'b1111;
    g_log.delete();
    @(negedge clk);
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_sel", sel, 2'd0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_out", out, a);
    tick();
    @(negedge clk);
    chk("first_gnt", gnt, 4'b0001);

    // full rotation
    repeat (20) tick();
    chk("rot_len", g_log.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < g_log.size()) chk("rot_order", g_log[i], rot[i]);
    @(negedge clk);
    chk("rot_gnt", gnt, 4'b0001);

    // single source b
    reset1();
    req = 4'b0010;
    fix_b = 1;
    b = 8'h5A;
    for (int i = 0; i < 4; i++) dut_acc[i] = 0;
    tick();
    @(negedge clk);
    chk("one_gnt", gnt, 4'b0010);
    chk("one_sel", sel, 2'd1);
    chk("one_out", out, 8'h5A);
    chk("one_valid", out_valid, 1'b1);
    repeat (4) tick();
    @(negedge clk);
    chk("one_idle_gnt", gnt, 4'b0000);
    chk("one_idle_valid", out_valid, 1'b0);
    chk("one_beats", dut_acc[1], 4);
    tick();
    @(negedge clk);
    chk("one_regrant", gnt, 4'b0010);
    fix_b = 0;

    // backpressure on c
    reset1();
    req = 4'b0100;
    for (int i = 0; i < 4; i++) dut_acc[i] = 0;
    for (int k = 0; k < 7; k++) begin
      tick();
      out_ready = pat[k];
      @(negedge clk);
      chk("bp_valid", out_valid, 1'b1);
    end
    chk("bp_gnt7", gnt, 4'b0100);
    chk("bp_acc7", dut_acc[2], 3);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel", gnt, 4'b0000);
    chk("bp_acc", dut_acc[2], 4);

    // withdrawal of a after two beats
    reset1();
    req = 4'b0101;
    tick();
    @(negedge clk);
    chk("wd_gnt", gnt, 4'b0001);
    tick();
    tick();
    req = 4'b0100;
    @(negedge clk);
    chk("wd_valid", out_valid, 1'b0);
    tick();
    req = 4'b0101;
    @(negedge clk);
    chk("wd_idle", gnt, 4'b0000);
    tick();
    @(negedge clk);
    chk("wd_next_c", gnt, 4'b0100);
    repeat (5) tick();
    @(negedge clk);
    chk("wd_then_a", gnt, 4'b0001);

    // reset in the middle of a d burst
    reset1();
    req = 4'b1000;
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("mr_gnt_d", gnt, 4'b1000);
    tick();
    rst = 1'b0;
    req = 4'b1001;
    @(negedge clk);
    chk("mr_gnt0", gnt, 4'b0000);
    chk("mr_valid0", out_valid, 1'b0);
    tick();
    @(negedge clk);
    chk("mr_a_first", gnt, 4'b0001);

    // mixed traffic checked by the model only
    repeat (80) begin
      tick();
      req = 4'($urandom);
      if ($urandom_range(0, 3) != 0) req = req | 4'b0001 << $urandom_range(0, 3);
      out_ready = 1'($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 39) == 0);
    end
    tick();
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
